// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared key codes, ALU op encodings and state encoding for the calculator entry stage
//
// Contents:
//   KEY_ADD..KEY_CLR  key codes delivered by keyboardCtrl (0x0-0x9 are digits)
//   alu_op_e          ALU operation encoding driven on alu_op
//   state_e           entry FSM state encoding
//   is_digit/is_op    key classification helpers
//   key_to_op         operator key -> ALU op encoding

package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    NUM1   = 3'd0,
    NUM2   = 3'd1,
    EXEC   = 3'd2,
    RESULT = 3'd3,
    ERROR  = 3'd4
  } state_e;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

  function automatic logic is_op(input logic [3:0] k);
    return (k >= KEY_ADD) && (k <= KEY_DIV);
  endfunction

  // Operator keys are contiguous, so the offset from KEY_ADD is the op code.
  function automatic alu_op_e key_to_op(input logic [3:0] k);
    logic [3:0] d;
    d = k - KEY_ADD;
    return alu_op_e'(d[1:0]);
  endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// rtl/bcd_entry_reg.sv - DIGITS-nibble BCD operand shift register with digit count and blank mask
//
// Ports:
//   CLK, RESET         clock, asynchronous active-high reset
//   clr                zero value and count (highest priority)
//   load, load_val,
//   load_cnt           parallel load of value and count
//   shift, digit       shift digit into the LSB nibble (no leading zeros, stops when full)
//   value, count       registered operand and digit count
//   value_nxt, blank_nxt  value and blank mask after this cycle's update, for registered display

module bcd_entry_reg #(
  parameter  int DIGITS = 4,
  localparam int W      = 4 * DIGITS,
  localparam int CNT_W  = $clog2(DIGITS + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             clr,
  input  logic             load,
  input  logic [W-1:0]     load_val,
  input  logic [CNT_W-1:0] load_cnt,
  input  logic             shift,
  input  logic [3:0]       digit,
  output logic [W-1:0]     value,
  output logic [CNT_W-1:0] count,
  output logic [W-1:0]     value_nxt,
  output logic [DIGITS-1:0] blank_nxt
);

  logic [CNT_W-1:0] count_nxt;

  always_comb begin
    value_nxt = value;
    count_nxt = count;
    if (clr) begin
      value_nxt = '0;
      count_nxt = '0;
    end else if (load) begin
      value_nxt = load_val;
      count_nxt = load_cnt;
    end else if (shift && (count < CNT_W'(DIGITS)) &&
                 !((count == '0) && (digit == 4'd0))) begin
      // A zero typed into an empty operand is a leading zero and is dropped.
      value_nxt = {value[W-5:0], digit};
      count_nxt = count + 1'b1;
    end
  end

  // Digit i is blank when it lies at or above max(count, 1): digit 0 always shows.
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      blank_nxt[i] = (i >= 1) && (i >= int'(count_nxt));
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      value <= '0;
      count <= '0;
    end else begin
      value <= value_nxt;
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/calc_entry_fsm.sv
// rtl/calc_entry_fsm.sv - calculator control: operand/operator entry, ALU start/done handshake, display drive
//
// Ports:
//   CLK, RESET            clock, asynchronous active-high reset
//   key_code, key_valid   key code and one-cycle strobe from keyboardCtrl
//   alu_num1, alu_num2    BCD operands to the ALU, stable throughout EXEC
//   alu_op                ALU operation (00 add, 01 sub, 10 mul, 11 div)
//   alu_start             one-cycle request pulse in the first EXEC cycle
//   alu_done, alu_err,
//   alu_res               ALU completion, error qualifier and BCD result
//   disp_bcd, disp_blank,
//   disp_err              registered display value, per-digit blank mask, error pattern
//   busy                  high while in EXEC

module calc_entry_fsm
  import calc_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int ALU_TIMEOUT = 255,
  parameter int TMO_W       = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [3:0]          key_code,
  input  logic                key_valid,
  output logic [4*DIGITS-1:0] alu_num1,
  output logic [4*DIGITS-1:0] alu_num2,
  output logic [1:0]          alu_op,
  output logic                alu_start,
  input  logic                alu_done,
  input  logic                alu_err,
  input  logic [4*DIGITS-1:0] alu_res,
  output logic [4*DIGITS-1:0] disp_bcd,
  output logic [DIGITS-1:0]   disp_blank,
  output logic                disp_err,
  output logic                busy
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ALU_TIMEOUT - 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  state_e           state, state_nxt;
  alu_op_e          op_q;
  logic [W-1:0]     res_q, res_nxt;
  logic [TMO_W-1:0] tmo_cnt;

  logic             n1_clr, n1_load, n1_shift;
  logic [W-1:0]     n1_load_val;
  logic [CNT_W-1:0] n1_load_cnt;
  logic             n2_clr, n2_shift;
  logic             op_load, res_load;

  logic [W-1:0]      n1_val, n1_val_nxt, n2_val, n2_val_nxt;
  logic [CNT_W-1:0]  n1_cnt_unused, n2_cnt;
  logic [DIGITS-1:0] n1_blank_nxt, n2_blank_nxt;

  logic [W-1:0]      disp_bcd_nxt;
  logic [DIGITS-1:0] disp_blank_nxt;
  logic              disp_err_nxt, alu_start_nxt, busy_nxt;

  // Number of significant digits (position of the top non-zero nibble + 1).
  function automatic logic [CNT_W-1:0] sig_digits(input logic [W-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] != 4'd0) n = CNT_W'(i + 1);
    end
    return n;
  endfunction

  function automatic logic [DIGITS-1:0] blank_for_count(input logic [CNT_W-1:0] c);
    logic [DIGITS-1:0] m;
    for (int i = 0; i < DIGITS; i++) m[i] = (i >= 1) && (i >= int'(c));
    return m;
  endfunction

  bcd_entry_reg #(.DIGITS(DIGITS)) u_num1 (
    .CLK       (CLK),
    .RESET     (RESET),
    .clr       (n1_clr),
    .load      (n1_load),
    .load_val  (n1_load_val),
    .load_cnt  (n1_load_cnt),
    .shift     (n1_shift),
    .digit     (key_code),
    .value     (n1_val),
    .count     (n1_cnt_unused),
    .value_nxt (n1_val_nxt),
    .blank_nxt (n1_blank_nxt)
  );

  bcd_entry_reg #(.DIGITS(DIGITS)) u_num2 (
    .CLK       (CLK),
    .RESET     (RESET),
    .clr       (n2_clr),
    .load      (1'b0),
    .load_val  ('0),
    .load_cnt  ('0),
    .shift     (n2_shift),
    .digit     (key_code),
    .value     (n2_val),
    .count     (n2_cnt),
    .value_nxt (n2_val_nxt),
    .blank_nxt (n2_blank_nxt)
  );

  // State register plus the datapath registers the FSM owns.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= NUM1;
      op_q    <= OP_ADD;
      res_q   <= '0;
      tmo_cnt <= '0;
    end else begin
      state <= state_nxt;
      res_q <= res_nxt;
      if (op_load) op_q <= key_to_op(key_code);
      // Counts cycles spent in EXEC; zero in the first EXEC cycle.
      if ((state == EXEC) && (state_nxt == EXEC)) tmo_cnt <= tmo_cnt + 1'b1;
      else                                        tmo_cnt <= '0;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_nxt   = state;
    n1_clr      = 1'b0;
    n1_load     = 1'b0;
    n1_load_val = res_q;
    n1_load_cnt = sig_digits(res_q);
    n1_shift    = 1'b0;
    n2_clr      = 1'b0;
    n2_shift    = 1'b0;
    op_load     = 1'b0;
    res_load    = 1'b0;

    if (state == EXEC) begin
      // Keys are dropped here; done wins over a timeout in the same cycle.
      if (alu_done) begin
        if (alu_err) begin
          state_nxt = ERROR;
        end else begin
          res_load  = 1'b1;
          state_nxt = RESULT;
        end
      end else if (tmo_cnt == TMO_LAST) begin
        state_nxt = ERROR;
      end
    end else if (key_valid) begin
      if (key_code == KEY_CLR) begin
        n1_clr    = 1'b1;
        n2_clr    = 1'b1;
        state_nxt = NUM1;
      end else begin
        case (state)
          NUM1: begin
            if (is_digit(key_code)) begin
              n1_shift = 1'b1;
            end else if (is_op(key_code)) begin
              op_load   = 1'b1;
              n2_clr    = 1'b1;
              state_nxt = NUM2;
            end
          end
          NUM2: begin
            if (is_digit(key_code)) begin
              n2_shift = 1'b1;
            end else if (is_op(key_code)) begin
              // Operator may be changed only until the second operand starts.
              if (n2_cnt == '0) op_load = 1'b1;
            end else if (key_code == KEY_EQ) begin
              if (n2_cnt != '0) state_nxt = EXEC;
            end
          end
          RESULT, ERROR: begin
            if (is_digit(key_code)) begin
              n1_load     = 1'b1;
              n1_load_val = W'(key_code);
              n1_load_cnt = CNT_W'(1);
              n2_clr      = 1'b1;
              state_nxt   = NUM1;
            end else if (is_op(key_code) && (state == RESULT)) begin
              // Chaining: the result becomes operand 1.
              n1_load   = 1'b1;
              op_load   = 1'b1;
              n2_clr    = 1'b1;
              state_nxt = NUM2;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign res_nxt = res_load ? alu_res : res_q;

  // Output decode from the next state so the registered display follows keys with one cycle latency.
  always_comb begin
    disp_bcd_nxt   = '0;
    disp_blank_nxt = '1;
    disp_err_nxt   = 1'b0;
    case (state_nxt)
      NUM1: begin
        disp_bcd_nxt   = n1_val_nxt;
        disp_blank_nxt = n1_blank_nxt;
      end
      NUM2, EXEC: begin
        disp_bcd_nxt   = n2_val_nxt;
        disp_blank_nxt = n2_blank_nxt;
      end
      RESULT: begin
        disp_bcd_nxt   = res_nxt;
        disp_blank_nxt = blank_for_count(sig_digits(res_nxt));
      end
      ERROR: begin
        disp_err_nxt = 1'b1;
      end
      default: ;
    endcase
    alu_start_nxt = (state_nxt == EXEC) && (state != EXEC);
    busy_nxt      = (state_nxt == EXEC);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      disp_bcd   <= '0;
      disp_blank <= BLANK_RST;
      disp_err   <= 1'b0;
      alu_start  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      disp_bcd   <= disp_bcd_nxt;
      disp_blank <= disp_blank_nxt;
      disp_err   <= disp_err_nxt;
      alu_start  <= alu_start_nxt;
      busy       <= busy_nxt;
    end
  end

  assign alu_num1 = n1_val;
  assign alu_num2 = n2_val;
  assign alu_op   = op_q;

endmodule

// File: doc/calc_entry_fsm.md
Name: calc_entry_fsm

Overview:
Main calculator control stage, directly downstream of keyboardCtrl. Consumes its BCDKey/KeyRead pulses, assembles two 4-digit BCD operands and an operator, and issues a start/done transaction to the ALU. Holds the value to show and drives a BCD word plus blank and error flags to the display path (bin2bcd/bcd_2seg scanner).

Parameters:
DIGITS, 4, number of BCD digits per operand; alu_num1, alu_num2, alu_res and disp_bcd are 4*DIGITS wide.
ALU_TIMEOUT, 255, maximum number of EXEC cycles to wait for alu_done before entering ERROR.
TMO_W, 8, width of the timeout counter; must hold ALU_TIMEOUT.

Ports:
CLK  in  1  system clock (LFOSC domain)
RESET  in  1  asynchronous reset, active-high
key_code  in  4  key code from keyboardCtrl (BCDKey)
key_valid  in  1  one-cycle pulse; key_code is valid (KeyRead)
alu_num1  out  16  operand 1, BCD
alu_num2  out  16  operand 2, BCD
alu_op  out  2  00 add, 01 sub, 10 mul, 11 div
alu_start  out  1  one-cycle request pulse
alu_done  in  1  ALU result valid, sampled only in EXEC
alu_err  in  1  qualifies alu_done: overflow or divide-by-zero
alu_res  in  16  ALU result, BCD
disp_bcd  out  16  value to display, BCD, digit 0 = LSB nibble
disp_blank  out  4  bit i = 1 blanks digit i
disp_err  out  1  display shows the error pattern
busy  out  1  high in EXEC

Behaviour:
- Clocking and reset: single clock CLK; RESET is asynchronous and active-high. All state is registered.
- Reset values: state NUM1; num1 = num2 = 0; digit counts = 0; alu_op = 00; alu_start = 0; busy = 0; disp_bcd = 0; disp_blank = 4'b1110; disp_err = 0. Reset in EXEC drops alu_start and busy immediately.
- Key map: 0x0-0x9 digit; 0xA add; 0xB sub; 0xC mul; 0xD div; 0xE equals; 0xF clear.
- Key timing: key_valid in cycle n updates state and registers at the edge ending cycle n. The new value is visible on disp_* in cycle n+1. Keys arriving in EXEC are dropped.
- Digit entry into the active operand (shift left one nibble, new digit in the LSB nibble, count + 1):
  - digit 0 while the operand is 0 with count 0: no change (no leading zeros);
  - digit while count = DIGITS: ignored.
- Display during entry: disp_bcd = active operand; disp_blank bit i = 1 for every i >= max(count, 1).
- Display in RESULT: disp_bcd = result; leading-zero suppression, except digit 0 is never blanked.
- Display in ERROR: disp_blank = 1111, disp_err = 1.
- Clear (0xF), any state except EXEC: go to NUM1, zero num1, num2 and counts.
- NUM1:
  - digit: enter into num1;
  - op: latch alu_op, clear num2, go to NUM2;
  - equals: ignored.
- NUM2:
  - digit: enter into num2;
  - op with num2 count 0: replace alu_op;
  - op with num2 count > 0: ignored;
  - equals with num2 count > 0: go to EXEC;
  - equals with num2 count 0: ignored.
- EXEC:
  - first cycle: alu_start = 1 for exactly one cycle;
  - alu_num1, alu_num2 and alu_op are held stable for the whole state;
  - alu_done may be accepted in any EXEC cycle, including the start cycle;
  - alu_done with alu_err = 0: capture alu_res into result, go to RESULT;
  - alu_done with alu_err = 1: go to ERROR;
  - timeout counter counts EXEC cycles; when it reaches ALU_TIMEOUT without alu_done, go to ERROR.
- RESULT:
  - digit: start a new num1 containing that digit, count 1, go to NUM1;
  - op: num1 = result, count = number of significant digits, latch op, clear num2, go to NUM2 (chaining);
  - equals: ignored.
- ERROR:
  - digit: as in RESULT but from zero;
  - op and equals: ignored.
- The display always tracks the active state's value; disp_* are registered outputs.

Decomposition:
- Shared package calc_pkg:
  - key code constants (KEY_ADD..KEY_CLR);
  - ALU op encodings;
  - state encoding (NUM1, NUM2, EXEC, RESULT, ERROR).
- One sub-module: bcd_entry_reg, instantiated twice (one per operand).
  - Provides a DIGITS-nibble shift register with digit count.
  - Operations: clear, shift-in digit, parallel load with count.
  - Also generates the blank mask.

Test Plan:
- Reset: RESET pulse -> disp_bcd = 0x0000, disp_blank = 1110, alu_start = 0, busy = 0.
- Entry and overflow: keys 1,2,3 -> disp_bcd = 0x0123, blank = 1000. Then keys 4,5 -> disp_bcd = 0x1234, blank = 0000; the 5 is ignored.
- Leading zeros and dropped keys: keys 0,0,7 -> disp_bcd = 0x0007, blank = 1110. A key pulse during EXEC is dropped (count unchanged).
- Basic add: keys 1,2,A,3,4,E with an ALU model answering 0x0046 after 3 cycles:
  - alu_num1 = 0x0012, alu_num2 = 0x0034, alu_op = 00;
  - alu_start high for exactly 1 cycle;
  - then disp_bcd = 0x0046, blank = 1100.
- Chaining: from result 0x0046, keys B,6,E -> alu_num1 = 0x0046, alu_op = 01, alu_num2 = 0x0006.
- Error paths:
  - alu_done with alu_err = 1 -> disp_err = 1, blank = 1111;
  - alu_done never asserted -> ERROR exactly ALU_TIMEOUT cycles after the start cycle;
  - key F -> NUM1, disp_bcd = 0, disp_err = 0;
  - RESET asserted mid-EXEC -> alu_start and busy low asynchronously.
